// File: rtl/ahb_timer_pkg.sv
// Shared register map and CONTROL/STATUS field positions for the AHB multi-channel timer.
package ahb_timer_pkg;

    localparam int CH_LSB  = 4;
    localparam int CH_W    = 3;
    localparam int REG_LSB = 2;
    localparam int REG_W   = 2;

    typedef enum logic [REG_W-1:0] {
        REG_LIMIT   = 2'd0,
        REG_CURRENT = 2'd1,
        REG_CONTROL = 2'd2,
        REG_STATUS  = 2'd3
    } reg_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_UP     = 1;
    localparam int CTRL_USELIM = 2;
    localparam int CTRL_PRESC  = 3;
    localparam int CTRL_IRQEN  = 4;
    localparam int CTRL_W      = 5;

    localparam int STAT_WRAP   = 0;

    // Field order mirrors the CTRL_* bit indices (first member is the MSB).
    typedef struct packed {
        logic irqen;
        logic presc;
        logic uselim;
        logic up;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: LIMIT/CURRENT/CONTROL/WRAP registers, up/down step rule and
// a registered interrupt output.
module timer_channel
    import ahb_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             tick,
    input  logic             wr_limit,
    input  logic             wr_current,
    input  logic             wr_control,
    input  logic             wr_status,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] current,
    output ctrl_t            control,
    output logic             wrap,
    output logic             irq
);

    logic [CNT_W-1:0] top;
    logic [CNT_W-1:0] step_val;
    logic             adv;
    logic             hit;
    ctrl_t            control_nxt;
    logic             wrap_nxt;

    always_comb begin
        top      = control.uselim ? limit : '1;
        adv      = control.en & (~control.presc | tick);
        hit      = 1'b0;
        step_val = current;
        if (control.up) begin
            if (current == top) begin
                step_val = '0;
                hit      = 1'b1;
            end else if (current > top) begin
                step_val = '0;
            end else begin
                step_val = current + 1'b1;
            end
        end else begin
            if (current == '0) begin
                step_val = top;
                hit      = 1'b1;
            end else if (current > top) begin
                step_val = top;
            end else begin
                step_val = current - 1'b1;
            end
        end
    end

    // A CURRENT write replaces the step entirely, so that step cannot raise WRAP.
    always_comb begin
        control_nxt = wr_control ? ctrl_t'(wdata[CTRL_W-1:0]) : control;
        wrap_nxt    = (adv & hit & ~wr_current)
                    | (wrap & ~(wr_status & wdata[STAT_WRAP]));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            limit   <= '1;
            current <= '0;
            control <= '0;
            wrap    <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_limit) begin
                limit <= wdata;
            end
            if (wr_current) begin
                current <= wdata;
            end else if (adv) begin
                current <= step_val;
            end
            control <= control_nxt;
            wrap    <= wrap_nxt;
            irq     <= wrap_nxt & control_nxt.irqen;
        end
    end

endmodule

// File: rtl/ahb_multi_timer.sv
// AHB-Lite slave with NUM_CH independent up/down timers sharing one free-running
// prescaler; zero wait state, per-channel and combined interrupts.
module ahb_multi_timer
    import ahb_timer_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 32,
    parameter int PRESC_DIV = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [NUM_CH-1:0] timer_irq_vec,
    output logic              timer_irq
);

    localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;

    logic [PW-1:0] presc_cnt;
    logic          tick;

    assign tick = (presc_cnt == PW'(PRESC_DIV - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        end
    end

    // Address phase -> data phase (_p1)
    logic            addr_vld;
    logic            vld_p1;
    logic            write_p1;
    logic [CH_W-1:0] ch_p1;
    reg_e            reg_p1;

    assign addr_vld = HSEL & HREADY & HTRANS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_p1   <= 1'b0;
            write_p1 <= 1'b0;
        end else begin
            vld_p1 <= addr_vld;
            if (addr_vld) begin
                write_p1 <= HWRITE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (addr_vld) begin
            ch_p1  <= HADDR[CH_LSB +: CH_W];
            reg_p1 <= reg_e'(HADDR[REG_LSB +: REG_W]);
        end
    end

    logic             wr_p1;
    logic [CNT_W-1:0] lim_q  [NUM_CH];
    logic [CNT_W-1:0] cur_q  [NUM_CH];
    ctrl_t            ctl_q  [NUM_CH];
    logic [NUM_CH-1:0] wrap_q;

    assign wr_p1 = vld_p1 & write_p1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel;
        assign sel = wr_p1 & (ch_p1 == CH_W'(g));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .HCLK       (HCLK),
            .HRESETn    (HRESETn),
            .tick       (tick),
            .wr_limit   (sel & (reg_p1 == REG_LIMIT)),
            .wr_current (sel & (reg_p1 == REG_CURRENT)),
            .wr_control (sel & (reg_p1 == REG_CONTROL)),
            .wr_status  (sel & (reg_p1 == REG_STATUS)),
            .wdata      (HWDATA[CNT_W-1:0]),
            .limit      (lim_q[g]),
            .current    (cur_q[g]),
            .control    (ctl_q[g]),
            .wrap       (wrap_q[g]),
            .irq        (timer_irq_vec[g])
        );
    end

    if (CNT_W < 32) begin : g_unused_wdata
        logic unused_hwdata;
        assign unused_hwdata = ^HWDATA[31:CNT_W];
    end

    logic unused_bus;
    assign unused_bus = ^{HADDR[31:CH_LSB+CH_W], HADDR[REG_LSB-1:0], HTRANS[0]};

    // Read mux; channels beyond NUM_CH match no loop entry and read as zero.
    always_comb begin
        HRDATA = '0;
        if (vld_p1 && !write_p1) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_p1 == CH_W'(i)) begin
                    case (reg_p1)
                        REG_LIMIT:   HRDATA[CNT_W-1:0]  = lim_q[i];
                        REG_CURRENT: HRDATA[CNT_W-1:0]  = cur_q[i];
                        REG_CONTROL: HRDATA[CTRL_W-1:0] = ctl_q[i];
                        REG_STATUS:  HRDATA[STAT_WRAP]  = wrap_q[i];
                        default:     HRDATA             = '0;
                    endcase
                end
            end
        end
    end

    assign timer_irq = |timer_irq_vec;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

endmodule
